id_ex_pipeline_reg: RTL
=======================

Name: id_ex_pipeline_reg

Overview:
- ID/EX pipeline register, directly downstream of the decode-stage control flush gating.
- Captures the gated decode control bundle plus operand/immediate/register-address fields each cycle and presents them to the EX stage.
- Supports a hold (stall), bubble insertion (flush) and a per-entry valid bit consumed by forwarding and hazard logic.

Parameters:
- DATA_W, 32, width of PC+4, operand and immediate fields.
- REG_ADDR_W, 5, width of rs/rt/rd register specifiers.
- CNT_W, 16, width of the optional bubble counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- id_stall  input  1  hold the current EX contents (EX stage busy).
- ex_flush  input  1  replace the next EX contents with a bubble (branch/jump redirect).
- id_valid  input  1  decode stage holds a real instruction.
- ID_RegDst, ID_ALUSrc, ID_MemtoReg, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_Branch, ID_JRControl  input  1 each  gated decode controls.
- ID_ALUOp  input  2  gated ALU op class.
- id_pc4, id_rdata1, id_rdata2, id_imm  input  DATA_W each  PC+4, register operands, sign-extended immediate.
- id_rs, id_rt, id_rd  input  REG_ADDR_W each  register specifiers.
- EX_RegDst, EX_ALUSrc, EX_MemtoReg, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Branch, EX_JRControl  output  1 each  registered controls.
- EX_ALUOp  output  2  registered ALU op class.
- ex_pc4, ex_rdata1, ex_rdata2, ex_imm  output  DATA_W each  registered data fields.
- ex_rs, ex_rt, ex_rd  output  REG_ADDR_W each  registered specifiers.
- ex_valid  output  1  EX stage holds a real instruction.
- bubble_cnt  output  CNT_W  bubbles inserted (only with the optional feature).

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - reset is synchronous, active-high. It is sampled on the rising edge of clk; there is no asynchronous path.
- Reset values: every output is 0, including all controls, EX_ALUOp, all data and specifier fields, ex_valid and bubble_cnt.
- Update priority on each rising edge: reset > ex_flush > id_stall > load.
- Load (no reset, no flush, no stall):
  - All EX_* and ex_* outputs take the corresponding ID_*/id_* inputs.
  - ex_valid <= id_valid.
  - Latency is exactly 1 cycle.
- Flush:
  - All ten control bits are cleared to 0 and ex_valid <= 0.
  - Data and specifier fields load from the inputs. They are don't-care, but must be deterministic so the bench can compare them.
  - The bubble has no architectural side effects: RegWrite, MemWrite, MemRead and Branch are all 0.
- Stall: every register holds its value, including ex_valid.
- Flush and stall together: flush wins. A redirect kills the held instruction and the bubble is written on that edge.
- Stall held N cycles: outputs stay constant for N cycles. The next non-stall edge loads whatever is present on the inputs then. Input-side hold is owned upstream.
- Reset asserted mid-stall or mid-flush: reset wins on that edge and all outputs go to 0.
- id_valid=0 with nonzero controls: the controls are registered as presented and ex_valid=0. Downstream must qualify with ex_valid.
- No combinational path from any input to any output. All outputs are direct register outputs.
- State view: two-state valid machine.
  - EMPTY (ex_valid=0) to FULL (ex_valid=1) on a load with id_valid=1.
  - FULL to EMPTY on flush, or on a load with id_valid=0.
  - Stall self-loops in both states.

Optional Feature:
- Macro: IDEX_BUBBLE_CNT_EN.
- With the macro defined:
  - bubble_cnt increments by 1 on every non-reset edge where ex_flush=1, or where the entry loads with id_valid=0 and id_stall=0.
  - It wraps from 2^CNT_W-1 to 0.
  - Stall edges do not count.
  - Reset clears it to 0.
- Without the macro: no counter flops; bubble_cnt is tied to 0.

Test Plan:
- Reset: assert reset 2 cycles with all inputs 1 → every output 0, ex_valid 0, bubble_cnt 0.
- Load: id_valid=1, ID_RegWrite=1, ID_ALUOp=2'b10, id_rdata1=32'h0000_1234, id_rd=5'd9 → exactly 1 cycle later EX_RegWrite=1, EX_ALUOp=2'b10, ex_rdata1=32'h0000_1234, ex_rd=9, ex_valid=1.
- Stall: load the sw control pattern (ID_MemWrite=1, ID_ALUSrc=1), then id_stall=1 for 3 cycles while the inputs change to 32'hDEAD_BEEF → outputs keep the sw pattern for 3 cycles. On release, the outputs take 32'hDEAD_BEEF.
- Flush overrides stall: ex_flush=1 and id_stall=1 with ID_MemWrite=1 → next cycle all controls 0, ex_valid=0; bubble_cnt +1 if IDEX_BUBBLE_CNT_EN.
- Reset mid-operation: reset=1 on the same edge as a valid load with ID_Branch=1 → EX_Branch=0, ex_valid=0.
- Counter wrap (CNT_W=4, macro on): 17 consecutive flushes → bubble_cnt = 1.

Source files
------------

// File: rtl/id_ex_pipeline_reg.sv
// ============================================================================
// id_ex_pipeline_reg
// ----------------------------------------------------------------------------
// ID/EX pipeline register. It sits directly after the decode-stage flush
// gating. Each cycle it captures the decode control bundle, the operand,
// immediate and PC+4 fields and the register specifiers, and presents them to
// the EX stage. It supports three operations:
//   - hold   (id_stall): the current EX contents stay as they are
//   - bubble (ex_flush): the controls are cleared and the entry becomes invalid
//   - load: the ID inputs are captured
//
// Update priority on each rising edge: reset > ex_flush > id_stall > load.
// All outputs come straight from flops. There is no combinational path from
// any input to any output.
//
// Optional feature (macro IDEX_BUBBLE_CNT_EN): bubble_cnt counts inserted
// bubbles. A bubble is any non-reset edge with ex_flush=1, or a load
// (id_stall=0) with id_valid=0. The count wraps modulo 2^CNT_W. When the macro
// is undefined there are no counter flops and bubble_cnt is tied to 0.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   id_stall, ex_flush   hold / bubble requests
//   id_valid             decode stage holds a real instruction
//   ID_* (8 x 1b, ALUOp) gated decode controls
//   id_pc4/rdata1/rdata2/imm  DATA_W data fields
//   id_rs/rt/rd          REG_ADDR_W register specifiers
//   EX_*, ex_*           registered copies presented to EX
//   ex_valid             EX stage holds a real instruction
//   bubble_cnt           bubble count (zero without IDEX_BUBBLE_CNT_EN)
// ============================================================================
module id_ex_pipeline_reg #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_stall,
   input  logic                  ex_flush,
   input  logic                  id_valid,
   input  logic                  ID_RegDst,
   input  logic                  ID_ALUSrc,
   input  logic                  ID_MemtoReg,
   input  logic                  ID_RegWrite,
   input  logic                  ID_MemRead,
   input  logic                  ID_MemWrite,
   input  logic                  ID_Branch,
   input  logic                  ID_JRControl,
   input  logic [1:0]            ID_ALUOp,
   input  logic [DATA_W-1:0]     id_pc4,
   input  logic [DATA_W-1:0]     id_rdata1,
   input  logic [DATA_W-1:0]     id_rdata2,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   output logic                  EX_RegDst,
   output logic                  EX_ALUSrc,
   output logic                  EX_MemtoReg,
   output logic                  EX_RegWrite,
   output logic                  EX_MemRead,
   output logic                  EX_MemWrite,
   output logic                  EX_Branch,
   output logic                  EX_JRControl,
   output logic [1:0]            EX_ALUOp,
   output logic [DATA_W-1:0]     ex_pc4,
   output logic [DATA_W-1:0]     ex_rdata1,
   output logic [DATA_W-1:0]     ex_rdata2,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_valid,
   output logic [CNT_W-1:0]      bubble_cnt
);

   localparam int CTRL_W = 10;

   // Control bundle layout, MSB to LSB:
   // RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, JRControl, ALUOp[1:0]
   logic [CTRL_W-1:0]     ctrl_in;

   logic [CTRL_W-1:0]     ctrl_d,   ctrl_q;
   logic [DATA_W-1:0]     pc4_d,    pc4_q;
   logic [DATA_W-1:0]     rdata1_d, rdata1_q;
   logic [DATA_W-1:0]     rdata2_d, rdata2_q;
   logic [DATA_W-1:0]     imm_d,    imm_q;
   logic [REG_ADDR_W-1:0] rs_d,     rs_q;
   logic [REG_ADDR_W-1:0] rt_d,     rt_q;
   logic [REG_ADDR_W-1:0] rd_d,     rd_q;
   logic                  valid_d,  valid_q;

   assign ctrl_in = {ID_RegDst, ID_ALUSrc, ID_MemtoReg, ID_RegWrite,
                     ID_MemRead, ID_MemWrite, ID_Branch, ID_JRControl, ID_ALUOp};

   // Next-state selection: flush beats stall, stall beats load
   always_comb begin
      ctrl_d   = ctrl_q;
      pc4_d    = pc4_q;
      rdata1_d = rdata1_q;
      rdata2_d = rdata2_q;
      imm_d    = imm_q;
      rs_d     = rs_q;
      rt_d     = rt_q;
      rd_d     = rd_q;
      valid_d  = valid_q;
      if (ex_flush) begin
         // The bubble still captures the data fields so that they are
         // deterministic. The cleared controls make it harmless.
         ctrl_d   = {CTRL_W{1'b0}};
         valid_d  = 1'b0;
         pc4_d    = id_pc4;
         rdata1_d = id_rdata1;
         rdata2_d = id_rdata2;
         imm_d    = id_imm;
         rs_d     = id_rs;
         rt_d     = id_rt;
         rd_d     = id_rd;
      end else if (id_stall) begin
         ctrl_d   = ctrl_q;
         valid_d  = valid_q;
      end else begin
         // Controls are taken as presented even when id_valid=0.
         // Downstream logic must qualify them with ex_valid.
         ctrl_d   = ctrl_in;
         valid_d  = id_valid;
         pc4_d    = id_pc4;
         rdata1_d = id_rdata1;
         rdata2_d = id_rdata2;
         imm_d    = id_imm;
         rs_d     = id_rs;
         rt_d     = id_rt;
         rd_d     = id_rd;
      end
   end

   // Pipeline register bank with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q   <= {CTRL_W{1'b0}};
         pc4_q    <= {DATA_W{1'b0}};
         rdata1_q <= {DATA_W{1'b0}};
         rdata2_q <= {DATA_W{1'b0}};
         imm_q    <= {DATA_W{1'b0}};
         rs_q     <= {REG_ADDR_W{1'b0}};
         rt_q     <= {REG_ADDR_W{1'b0}};
         rd_q     <= {REG_ADDR_W{1'b0}};
         valid_q  <= 1'b0;
      end else begin
         ctrl_q   <= ctrl_d;
         pc4_q    <= pc4_d;
         rdata1_q <= rdata1_d;
         rdata2_q <= rdata2_d;
         imm_q    <= imm_d;
         rs_q     <= rs_d;
         rt_q     <= rt_d;
         rd_q     <= rd_d;
         valid_q  <= valid_d;
      end
   end

   assign EX_RegDst    = ctrl_q[9];
   assign EX_ALUSrc    = ctrl_q[8];
   assign EX_MemtoReg  = ctrl_q[7];
   assign EX_RegWrite  = ctrl_q[6];
   assign EX_MemRead   = ctrl_q[5];
   assign EX_MemWrite  = ctrl_q[4];
   assign EX_Branch    = ctrl_q[3];
   assign EX_JRControl = ctrl_q[2];
   assign EX_ALUOp     = ctrl_q[1:0];
   assign ex_pc4       = pc4_q;
   assign ex_rdata1    = rdata1_q;
   assign ex_rdata2    = rdata2_q;
   assign ex_imm       = imm_q;
   assign ex_rs        = rs_q;
   assign ex_rt        = rt_q;
   assign ex_rd        = rd_q;
   assign ex_valid     = valid_q;

`ifdef IDEX_BUBBLE_CNT_EN
   logic [CNT_W-1:0] cnt_d, cnt_q;

   // A bubble enters EX on a flush, or on a load of an invalid decode slot
   always_comb begin
      cnt_d = cnt_q;
      if (ex_flush || (!id_stall && !id_valid)) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Bubble counter register, wraps naturally at 2^CNT_W
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bubble_cnt = cnt_q;
`else
   assign bubble_cnt = {CNT_W{1'b0}};
`endif

endmodule
